// File: rtl/ipsec_buf_pkg.sv
// Shared sizing and state encodings for the crypto-engine channel buffers.
package ipsec_buf_pkg;

    localparam int NCH   = 8;
    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {IB_EMPTY = 1'b0, IB_FULL  = 1'b1} ib_state_e;
    typedef enum logic {OB_FREE  = 1'b0, OB_READY = 1'b1} ob_state_e;

endpackage

// File: rtl/ipsec_chan_slot.sv
// One channel: inbound/outbound ownership FSMs, both buffers and the sticky error bit.
//
// state    | meaning
// IB_EMPTY | inbound buffer owned by host, host may write
// IB_FULL  | inbound buffer handed to crypto, host writes rejected
// OB_FREE  | outbound buffer owned by crypto, crypto may write
// OB_READY | outbound buffer holds a result, host may drain
module ipsec_chan_slot
    import ipsec_buf_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_ib_done,
    input  logic          i_ob_done,
    input  logic          i_host_wr_en,
    input  logic [AW-1:0] i_host_wr_addr,
    input  logic [DW-1:0] i_host_wr_data,
    input  logic          i_host_commit,
    input  logic [AW-1:0] i_host_rd_addr,
    output logic [DW-1:0] o_host_rd_word,
    input  logic          i_host_release,
    input  logic          i_err_clr,
    output logic          o_ib_valid,
    output logic          o_ob_free,
    output logic          o_ob_ready,
    output logic          o_err
);

    ib_state_e     r_ib_state, w_ib_next;
    ob_state_e     r_ob_state, w_ob_next;
    logic          r_err, w_err_next, w_err_set;
    logic          w_host_wr_ok, w_wr_ok;
    logic [DW-1:0] r_ib_mem [DEPTH];
    logic [DW-1:0] r_ob_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    always_comb begin
        w_ib_next    = r_ib_state;
        w_ob_next    = r_ob_state;
        w_err_set    = 1'b0;
        w_host_wr_ok = i_host_wr_en && (r_ib_state == IB_EMPTY);
        w_wr_ok      = i_wr_en && (r_ob_state == OB_FREE);

        case (r_ib_state)
            IB_EMPTY: begin
                if (i_host_commit) w_ib_next = IB_FULL;
                if (i_ib_done)     w_err_set = 1'b1;
            end
            IB_FULL: begin
                if (i_ib_done) w_ib_next = IB_EMPTY;
                if (i_host_commit || i_host_wr_en) w_err_set = 1'b1;
            end
        endcase

        case (r_ob_state)
            OB_FREE: begin
                if (i_ob_done)      w_ob_next = OB_READY;
                if (i_host_release) w_err_set = 1'b1;
            end
            OB_READY: begin
                if (i_host_release) w_ob_next = OB_FREE;
                if (i_ob_done || i_wr_en) w_err_set = 1'b1;
            end
        endcase

        // a new violation outranks a clear arriving in the same cycle
        w_err_next = w_err_set ? 1'b1 : (i_err_clr ? 1'b0 : r_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ib_state <= IB_EMPTY;
            r_ob_state <= OB_FREE;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_ib_state <= w_ib_next;
            r_ob_state <= w_ob_next;
            r_err      <= w_err_next;
            if (i_rd_en) r_rd_data <= r_ib_mem[i_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_host_wr_ok) r_ib_mem[i_host_wr_addr] <= i_host_wr_data;
        if (w_wr_ok)      r_ob_mem[i_wr_addr]      <= i_wr_data;
    end

    assign o_rd_data      = r_rd_data;
    assign o_host_rd_word = r_ob_mem[i_host_rd_addr];
    assign o_ib_valid     = (r_ib_state == IB_FULL);
    assign o_ob_free      = (r_ob_state == OB_FREE);
    assign o_ob_ready     = (r_ob_state == OB_READY);
    assign o_err          = r_err;

endmodule

// File: rtl/ipsec_chan_buf.sv
// Channel buffer array for the crypto engine: host port decode plus registered host read mux.
module ipsec_chan_buf
    import ipsec_buf_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           RdEn,
    input  logic [NCH-1:0][31:0]     RdAddr,
    output logic [NCH-1:0][DW-1:0]   RdData,
    input  logic [NCH-1:0]           WrEn,
    input  logic [NCH-1:0][31:0]     WrAddr,
    input  logic [NCH-1:0][DW-1:0]   WrData,
    output logic [NCH-1:0]           IbIPSECValid,
    input  logic [NCH-1:0]           IbPCIeValid,
    output logic [NCH-1:0]           ObIPSECValid,
    input  logic [NCH-1:0]           ObPCIeValid,
    input  logic                     dma_wr_en,
    input  logic [2:0]               dma_wr_ch,
    input  logic [AW-1:0]            dma_wr_addr,
    input  logic [DW-1:0]            dma_wr_data,
    input  logic                     dma_ib_commit,
    input  logic                     dma_rd_en,
    input  logic [2:0]               dma_rd_ch,
    input  logic [AW-1:0]            dma_rd_addr,
    output logic [DW-1:0]            dma_rd_data,
    input  logic                     dma_ob_release,
    output logic [NCH-1:0]           ob_ready,
    output logic [NCH-1:0]           err,
    input  logic [NCH-1:0]           err_clr
);

    logic [NCH-1:0][DW-1:0] w_ob_word;
    logic [DW-1:0]          r_dma_rd_data;
    logic                   w_unused_addr_hi;

    // only the low AW address bits index a buffer; the rest alias
    assign w_unused_addr_hi = ^{RdAddr, WrAddr};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic w_wr_sel, w_rd_sel;
        assign w_wr_sel = (dma_wr_ch == 3'(c));
        assign w_rd_sel = (dma_rd_ch == 3'(c));

        ipsec_chan_slot u_slot (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_rd_en        (RdEn[c]),
            .i_rd_addr      (RdAddr[c][AW-1:0]),
            .o_rd_data      (RdData[c]),
            .i_wr_en        (WrEn[c]),
            .i_wr_addr      (WrAddr[c][AW-1:0]),
            .i_wr_data      (WrData[c]),
            .i_ib_done      (IbPCIeValid[c]),
            .i_ob_done      (ObPCIeValid[c]),
            .i_host_wr_en   (dma_wr_en && w_wr_sel),
            .i_host_wr_addr (dma_wr_addr),
            .i_host_wr_data (dma_wr_data),
            .i_host_commit  (dma_ib_commit && w_wr_sel),
            .i_host_rd_addr (dma_rd_addr),
            .o_host_rd_word (w_ob_word[c]),
            .i_host_release (dma_ob_release && w_rd_sel),
            .i_err_clr      (err_clr[c]),
            .o_ib_valid     (IbIPSECValid[c]),
            .o_ob_free      (ObIPSECValid[c]),
            .o_ob_ready     (ob_ready[c]),
            .o_err          (err[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dma_rd_data <= '0;
        end else if (dma_rd_en) begin
            r_dma_rd_data <= w_ob_word[dma_rd_ch];
        end
    end

    assign dma_rd_data = r_dma_rd_data;

endmodule

// File: tb/tb_ipsec_chan_buf.sv
// Directed table-driven bench for ipsec_chan_buf plus hand-written multi-cycle sequences.
module tb_ipsec_chan_buf;
    import ipsec_buf_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NCH-1:0]         RdEn;
    logic [NCH-1:0][31:0]   RdAddr;
    logic [NCH-1:0][DW-1:0] RdData;
    logic [NCH-1:0]         WrEn;
    logic [NCH-1:0][31:0]   WrAddr;
    logic [NCH-1:0][DW-1:0] WrData;
    logic [NCH-1:0]         IbIPSECValid, IbPCIeValid, ObIPSECValid, ObPCIeValid;
    logic                   dma_wr_en, dma_ib_commit, dma_rd_en, dma_ob_release;
    logic [2:0]             dma_wr_ch, dma_rd_ch;
    logic [AW-1:0]          dma_wr_addr, dma_rd_addr;
    logic [DW-1:0]          dma_wr_data, dma_rd_data;
    logic [NCH-1:0]         ob_ready, err, err_clr;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum {OP_IDLE, OP_HWR, OP_COMMIT, OP_CRD, OP_IBDONE, OP_CWR,
                  OP_OBDONE, OP_HRD, OP_REL, OP_ERRCLR} op_e;
    typedef enum {CHK_IBV, CHK_OBV, CHK_OBR, CHK_ERR, CHK_RDDATA, CHK_DMARD} chk_e;

    typedef struct {
        op_e           op;
        int            ch;
        logic [31:0]   addr;
        logic [DW-1:0] data;
        chk_e          chk;
        logic [DW-1:0] exp;
        string         name;
    } vec_t;

    vec_t vecs[$];

    ipsec_chan_buf dut (
        .clk(clk), .rst_n(rst_n),
        .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .IbIPSECValid(IbIPSECValid), .IbPCIeValid(IbPCIeValid),
        .ObIPSECValid(ObIPSECValid), .ObPCIeValid(ObPCIeValid),
        .dma_wr_en(dma_wr_en), .dma_wr_ch(dma_wr_ch), .dma_wr_addr(dma_wr_addr),
        .dma_wr_data(dma_wr_data), .dma_ib_commit(dma_ib_commit),
        .dma_rd_en(dma_rd_en), .dma_rd_ch(dma_rd_ch), .dma_rd_addr(dma_rd_addr),
        .dma_rd_data(dma_rd_data), .dma_ob_release(dma_ob_release),
        .ob_ready(ob_ready), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        RdEn = '0; RdAddr = '0; WrEn = '0; WrAddr = '0; WrData = '0;
        IbPCIeValid = '0; ObPCIeValid = '0; err_clr = '0;
        dma_wr_en = 1'b0; dma_wr_ch = '0; dma_wr_addr = '0; dma_wr_data = '0;
        dma_ib_commit = 1'b0; dma_rd_en = 1'b0; dma_rd_ch = '0; dma_rd_addr = '0;
        dma_ob_release = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input op_e op, input int ch, input logic [31:0] addr,
                            input logic [DW-1:0] data);
        logic [2:0] c3;
        c3 = ch[2:0];
        case (op)
            OP_HWR:    begin dma_wr_en = 1'b1; dma_wr_ch = c3; dma_wr_addr = addr[AW-1:0]; dma_wr_data = data; end
            OP_COMMIT: begin dma_ib_commit = 1'b1; dma_wr_ch = c3; end
            OP_CRD:    begin RdEn[ch] = 1'b1; RdAddr[ch] = addr; end
            OP_IBDONE: IbPCIeValid[ch] = 1'b1;
            OP_CWR:    begin WrEn[ch] = 1'b1; WrAddr[ch] = addr; WrData[ch] = data; end
            OP_OBDONE: ObPCIeValid[ch] = 1'b1;
            OP_HRD:    begin dma_rd_en = 1'b1; dma_rd_ch = c3; dma_rd_addr = addr[AW-1:0]; end
            OP_REL:    begin dma_ob_release = 1'b1; dma_rd_ch = c3; end
            OP_ERRCLR: err_clr[ch] = 1'b1;
            default:   ;
        endcase
    endtask

    task automatic op1(input op_e op, input int ch, input logic [31:0] addr,
                       input logic [DW-1:0] data);
        drive_op(op, ch, addr, data);
        step();
        clr_inputs();
    endtask

    task automatic add(input op_e op, input int ch, input logic [31:0] addr,
                       input logic [DW-1:0] data, input chk_e chk,
                       input logic [DW-1:0] exp, input string name);
        vec_t v;
        v.op = op; v.ch = ch; v.addr = addr; v.data = data;
        v.chk = chk; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    function automatic logic [DW-1:0] actual(input chk_e chk, input int ch);
        case (chk)
            CHK_IBV:    return DW'(IbIPSECValid);
            CHK_OBV:    return DW'(ObIPSECValid);
            CHK_OBR:    return DW'(ob_ready);
            CHK_ERR:    return DW'(err);
            CHK_RDDATA: return RdData[ch];
            default:    return dma_rd_data;
        endcase
    endfunction

    task automatic gap();
        repeat ($urandom_range(0, 3)) step();
    endtask

    initial begin
        logic [DW-1:0] e;

        clr_inputs();
        rst_n = 1'b0;
        #12;
        check("reset_ibv", DW'(IbIPSECValid), '0);
        check("reset_obv", DW'(ObIPSECValid), DW'(8'hFF));
        check("reset_obr", DW'(ob_ready), '0);
        check("reset_err", DW'(err), '0);
        check("reset_rddata", DW'(|RdData), '0);
        check("reset_dmard", dma_rd_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < DEPTH; i++) op1(OP_HWR, 3, i, DW'(32'h1000 + i));

        add(OP_COMMIT, 3, 0,     0,         CHK_IBV,    8'h08,   "fill_commit_ch3");
        add(OP_CRD,    3, 5,     0,         CHK_RDDATA, 'h1005,  "fill_read_ch3_w5");
        add(OP_IBDONE, 3, 0,     0,         CHK_IBV,    8'h00,   "fill_done_ch3");
        add(OP_CWR,    0, 2,     'hABCD,    CHK_OBV,    8'hFF,   "ob_write_ch0");
        add(OP_OBDONE, 0, 0,     0,         CHK_OBV,    8'hFE,   "ob_done_obv");
        add(OP_IDLE,   0, 0,     0,         CHK_OBR,    8'h01,   "ob_done_obr");
        add(OP_HRD,    0, 2,     0,         CHK_DMARD,  'hABCD,  "ob_host_read");
        add(OP_REL,    0, 0,     0,         CHK_OBV,    8'hFF,   "ob_release_obv");
        add(OP_IDLE,   0, 0,     0,         CHK_OBR,    8'h00,   "ob_release_obr");
        add(OP_HWR,    1, 4,     'h1111,    CHK_ERR,    8'h00,   "own_write_empty");
        add(OP_COMMIT, 1, 0,     0,         CHK_IBV,    8'h02,   "own_commit_ch1");
        add(OP_HWR,    1, 4,     'h2222,    CHK_ERR,    8'h02,   "own_write_full_err");
        add(OP_CRD,    1, 4,     0,         CHK_RDDATA, 'h1111,  "own_word_unchanged");
        add(OP_ERRCLR, 1, 0,     0,         CHK_ERR,    8'h00,   "own_err_clr");
        add(OP_CRD,    3, 'h13,  0,         CHK_RDDATA, 'h1003,  "alias_read_0x13");
        add(OP_IDLE,   3, 0,     0,         CHK_RDDATA, 'h1003,  "rddata_hold");
        add(OP_IBDONE, 2, 0,     0,         CHK_ERR,    8'h04,   "ibdone_empty_err");
        add(OP_IDLE,   0, 0,     0,         CHK_IBV,    8'h02,   "ibdone_empty_state");
        add(OP_ERRCLR, 2, 0,     0,         CHK_ERR,    8'h00,   "err_clr_ch2");
        add(OP_REL,    5, 0,     0,         CHK_ERR,    8'h20,   "release_free_err");
        add(OP_IDLE,   0, 0,     0,         CHK_OBV,    8'hFF,   "release_free_state");
        add(OP_ERRCLR, 5, 0,     0,         CHK_ERR,    8'h00,   "err_clr_ch5");
        add(OP_CWR,    6, 'h21,  'h6060,    CHK_ERR,    8'h00,   "cwr_alias_ch6");
        add(OP_OBDONE, 6, 0,     0,         CHK_OBR,    8'h40,   "obdone_ch6");
        add(OP_OBDONE, 6, 0,     0,         CHK_ERR,    8'h40,   "obdone_ready_err");
        add(OP_ERRCLR, 6, 0,     0,         CHK_ERR,    8'h00,   "err_clr_ch6");
        add(OP_CWR,    6, 1,     'h6666,    CHK_ERR,    8'h40,   "cwr_ready_err");
        add(OP_HRD,    6, 1,     0,         CHK_DMARD,  'h6060,  "cwr_ready_dropped");
        add(OP_IDLE,   0, 0,     0,         CHK_DMARD,  'h6060,  "dmard_hold");
        add(OP_COMMIT, 1, 0,     0,         CHK_ERR,    8'h42,   "commit_full_err");
        add(OP_ERRCLR, 6, 0,     0,         CHK_ERR,    8'h02,   "err_clr_ch6_only");
        add(OP_ERRCLR, 1, 0,     0,         CHK_ERR,    8'h00,   "err_clr_ch1");
        add(OP_REL,    6, 0,     0,         CHK_OBV,    8'hFF,   "release_ch6");

        foreach (vecs[k]) begin
            drive_op(vecs[k].op, vecs[k].ch, vecs[k].addr, vecs[k].data);
            step();
            clr_inputs();
            check(vecs[k].name, actual(vecs[k].chk, vecs[k].ch), vecs[k].exp);
        end

        // ch1 still IB_FULL: violation and clear in the same cycle
        drive_op(OP_HWR, 1, 0, 'h9);
        drive_op(OP_ERRCLR, 1, 0, 0);
        step(); clr_inputs();
        check("set_clr_same_cycle", DW'(err), DW'(8'h02));
        op1(OP_ERRCLR, 1, 0, 0);
        check("set_clr_then_clr", DW'(err), '0);

        drive_op(OP_HWR, 7, 9, 'h7777);
        drive_op(OP_COMMIT, 7, 0, 0);
        step(); clr_inputs();
        check("wr_commit_same_ibv", DW'(IbIPSECValid), DW'(8'h82));
        op1(OP_CRD, 7, 9, 0);
        check("wr_commit_same_data", RdData[7], 'h7777);

        drive_op(OP_CWR, 2, 3, 'h2323);
        drive_op(OP_OBDONE, 2, 0, 0);
        step(); clr_inputs();
        check("cwr_obdone_same_obr", DW'(ob_ready), DW'(8'h04));
        op1(OP_HRD, 2, 3, 0);
        check("cwr_obdone_same_data", dma_rd_data, 'h2323);
        op1(OP_REL, 2, 0, 0);

        op1(OP_HWR, 4, 0, 'hAAAA);
        drive_op(OP_CRD, 4, 0, 0);
        drive_op(OP_HWR, 4, 0, 'hBBBB);
        step(); clr_inputs();
        check("rbw_old_data", RdData[4], 'hAAAA);
        op1(OP_CRD, 4, 0, 0);
        check("rbw_new_data", RdData[4], 'hBBBB);
        check("corner_err_zero", DW'(err), '0);

        // mid-operation reset with every channel owned by crypto/host
        for (int c = 0; c < NCH; c++) op1(OP_COMMIT, c, 0, 0);
        for (int c = 0; c < NCH; c++) drive_op(OP_OBDONE, c, 0, 0);
        step(); clr_inputs();
        check("pre_reset_ibv", DW'(IbIPSECValid), DW'(8'hFF));
        check("pre_reset_obr", DW'(ob_ready), DW'(8'hFF));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ibv", DW'(IbIPSECValid), '0);
        check("async_reset_obv", DW'(ObIPSECValid), DW'(8'hFF));
        check("async_reset_obr", DW'(ob_ready), '0);
        check("async_reset_err", DW'(err), '0);
        check("async_reset_rddata", DW'(|RdData), '0);
        check("async_reset_dmard", dma_rd_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // all channels in overlapping traffic with random gaps
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < DEPTH; i++) op1(OP_HWR, c, i, DW'(32'hC000 + c * 256 + i));
            gap();
        end
        for (int c = 0; c < NCH; c++) begin
            op1(OP_COMMIT, c, 0, 0);
            gap();
        end
        check("conc_ibv_all", DW'(IbIPSECValid), DW'(8'hFF));
        for (int c = 0; c < NCH; c++) drive_op(OP_CRD, c, 32'h100 + 2 * c, 0);
        step(); clr_inputs();
        for (int c = 0; c < NCH; c++) begin
            e = DW'(32'hC000 + c * 256 + ((2 * c) % DEPTH));
            check($sformatf("conc_rd_ch%0d", c), RdData[c], e);
        end
        for (int c = NCH - 1; c >= 0; c--) begin
            op1(OP_IBDONE, c, 0, 0);
            gap();
        end
        for (int c = 0; c < NCH; c++) drive_op(OP_CWR, c, 15 - c, DW'(32'hD000 + c));
        step(); clr_inputs();
        for (int c = 0; c < NCH; c++) drive_op(OP_OBDONE, c, 0, 0);
        step(); clr_inputs();
        check("conc_obr_all", DW'(ob_ready), DW'(8'hFF));
        for (int c = 0; c < NCH; c++) begin
            op1(OP_HRD, c, 15 - c, 0);
            check($sformatf("conc_hrd_ch%0d", c), dma_rd_data, DW'(32'hD000 + c));
            gap();
            op1(OP_REL, c, 0, 0);
        end
        check("conc_err", DW'(err), '0);
        check("conc_ibv_end", DW'(IbIPSECValid), '0);
        check("conc_obv_end", DW'(ObIPSECValid), DW'(8'hFF));
        check("conc_obr_end", DW'(ob_ready), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
